// File: rtl/softmax_pkg.sv
// Shared constants, FSM state type and sum-width helper for the softmax normalisation stage.
package softmax_pkg;

  localparam int N_DEF     = 16;
  localparam int EXP_W_DEF = 32;
  localparam int OUT_W_DEF = 16;

  typedef enum logic [1:0] {ACCUM, DIV, OUT} norm_state_t;

  // A row of n values of exp_w bits summed without overflow.
  function automatic int sum_w(input int n, input int exp_w);
    return exp_w + $clog2(n);
  endfunction

  localparam int SUM_W = sum_w(N_DEF, EXP_W_DEF);

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle; done pulses QW cycles after start.
// Requires dividend/divisor < 2^QW, so the initial partial remainder is below the divisor.
module seq_divider #(
  parameter int DW  = 48,
  parameter int DSW = 36,
  parameter int QW  = 17
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [DW-1:0]  dividend,
  input  logic [DSW-1:0] divisor,
  output logic           done,
  output logic [QW-1:0]  quotient,
  output logic           div_by_zero
);
  localparam int STW = $clog2(QW);
  localparam int RW  = DW - QW;

  logic           run;
  logic [STW-1:0] step;
  logic [DSW-1:0] rem;
  logic [DSW-1:0] den;
  logic [QW-1:0]  shreg;
  logic [QW-2:0]  q;
  logic [DSW:0]   trial;
  logic [DSW:0]   diff;
  logic           ge;

  // With rem < den the borrow bit alone tells whether the trial subtract fits.
  always_comb begin
    trial       = {rem, shreg[QW-1]};
    diff        = trial - {1'b0, den};
    ge          = ~diff[DSW];
    quotient    = {q, ge};
    done        = run && (step == STW'(QW-1));
    div_by_zero = (den == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run   <= 1'b0;
      step  <= '0;
      rem   <= '0;
      den   <= '0;
      shreg <= '0;
      q     <= '0;
    end else if (start) begin
      run   <= 1'b1;
      step  <= '0;
      rem   <= {{(DSW-RW){1'b0}}, dividend[DW-1:QW]};
      den   <= divisor;
      shreg <= dividend[QW-1:0];
      q     <= '0;
    end else if (run) begin
      rem   <= ge ? diff[DSW-1:0] : trial[DSW-1:0];
      shreg <= {shreg[QW-2:0], 1'b0};
      q     <= quotient[QW-2:0];
      step  <= step + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/softmax_norm.sv
// Accumulates a row of N exponents into Sum_exp, then emits exp[i]/Sum_exp as Q0.OUT_W probabilities.
// exp_ready is low outside ACCUM; each prob is held until prob_ready.
module softmax_norm
  import softmax_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int EXP_W = EXP_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         exp_valid,
  input  logic [EXP_W-1:0]             exp,
  output logic                         exp_ready,
  output logic                         sum_valid,
  output logic [EXP_W+$clog2(N)-1:0]   Sum_exp,
  output logic                         prob_valid,
  output logic [OUT_W-1:0]             prob,
  output logic [$clog2(N)-1:0]         prob_idx,
  output logic                         prob_last,
  input  logic                         prob_ready,
  output logic                         busy
);
  localparam int CW = $clog2(N);
  localparam int SW = sum_w(N, EXP_W);
  localparam int QW = OUT_W + 1;
  localparam int DW = EXP_W + OUT_W;

  norm_state_t      state, state_nxt;
  logic [CW-1:0]    cnt, idx, sel_idx;
  logic [SW-1:0]    acc, acc_nxt, divisor;
  logic [EXP_W-1:0] elem_buf [N];
  logic [EXP_W-1:0] elem_sel;
  logic             accept, row_done, out_hs, next_elem, div_start;
  logic             div_done, div_zero;
  logic [QW-1:0]    quotient;
  logic [OUT_W-1:0] prob_nxt;

  assign accept    = exp_valid && (state == ACCUM);
  assign row_done  = accept && (cnt == CW'(N-1));
  assign out_hs    = (state == OUT) && prob_ready;
  assign next_elem = out_hs && (idx != CW'(N-1));
  assign acc_nxt   = acc + SW'(exp);
  assign busy      = (state != ACCUM) || (cnt != '0);

  // The divider starts on the same edge that finalises the sum or retires a prob,
  // so the final sum and the next element are fed straight in.
  assign div_start = row_done || next_elem;
  assign sel_idx   = row_done ? '0 : idx + 1'b1;
  assign elem_sel  = (row_done && cnt == '0) ? exp : elem_buf[sel_idx];
  assign divisor   = row_done ? acc_nxt : Sum_exp;

  seq_divider #(.DW(DW), .DSW(SW), .QW(QW)) u_div (
    .clk         (clk),
    .reset       (reset),
    .start       (div_start),
    .dividend    ({elem_sel, {OUT_W{1'b0}}}),
    .divisor     (divisor),
    .done        (div_done),
    .quotient    (quotient),
    .div_by_zero (div_zero)
  );

  always_comb begin
    if (div_zero)           prob_nxt = '0;
    else if (quotient[QW-1]) prob_nxt = '1;
    else                    prob_nxt = quotient[OUT_W-1:0];
  end

  always_comb begin
    state_nxt  = state;
    exp_ready  = 1'b0;
    prob_valid = 1'b0;
    case (state)
      ACCUM: begin
        exp_ready = 1'b1;
        if (row_done) state_nxt = DIV;
      end
      DIV: if (div_done) state_nxt = OUT;
      OUT: begin
        prob_valid = 1'b1;
        if (out_hs) state_nxt = (idx == CW'(N-1)) ? ACCUM : DIV;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) elem_buf[cnt] <= exp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACCUM;
      cnt       <= '0;
      idx       <= '0;
      acc       <= '0;
      Sum_exp   <= '0;
      sum_valid <= 1'b0;
      prob      <= '0;
      prob_idx  <= '0;
      prob_last <= 1'b0;
    end else begin
      state     <= state_nxt;
      sum_valid <= row_done;
      if (row_done) begin
        cnt     <= '0;
        acc     <= '0;
        idx     <= '0;
        Sum_exp <= acc_nxt;
      end else if (accept) begin
        cnt <= cnt + 1'b1;
        acc <= acc_nxt;
      end
      if (next_elem) idx <= idx + 1'b1;
      if (state == DIV && div_done) begin
        prob      <= prob_nxt;
        prob_idx  <= idx;
        prob_last <= (idx == CW'(N-1));
      end
    end
  end

endmodule
